sfif_cpl_credit: RTL and testbench
==================================

Name: sfif_cpl_credit

Overview:
Completion credit return engine for the SFIF receive path. It monitors received TLP starts and decodes all completion types (Cpl, CplD, CplLk, CplDLk). It converts each completion into header and data credits and accumulates them. Credits go back to the PCIe core through a valid/ready return port, either immediately on receive (mode 0) or when the user logic signals that it has consumed the completion from its buffer (mode 1).

Parameters:
DATA_W, 64, rx_data width; header DW0 occupies rx_data[DATA_W-1:DATA_W-32]
RELEASE_MODE, 0, 0 = release on receive; 1 = release on tlp_done
DEPTH, 16, per-TLP credit FIFO entries (mode 1 only); power of two, >= 2
HCR_W, 8, header credit accumulator and return width
DCR_W, 12, data credit accumulator width
MAX_H_RET, 8, max header credits per return beat
MAX_D_RET, 255, max data credits per return beat; must fit 8 bits

Ports:
clk_125  input  1  system clock
rst  input  1  asynchronous reset, active high
rx_st  input  1  first beat of a received TLP
rx_data  input  DATA_W  receive data; header DW0 in top 32 bits on rx_st
tlp_done  input  1  one-cycle pulse: oldest received completion has been consumed (mode 1; ignored in mode 0)
cr_ready  input  1  core accepts the current return beat
cr_valid  output  1  return beat valid
cplh_cr  output  HCR_W  header credits in the return beat
cpld_cr  output  8  data credits in the return beat
pend_cplh  output  HCR_W  header credits accumulated, not yet presented
pend_cpld  output  DCR_W  data credits accumulated, not yet presented
fifo_full  output  1  credit FIFO full (always 0 in mode 0)
err_ovf  output  1  sticky: FIFO overflow or accumulator saturation
err_unf  output  1  sticky: tlp_done received while FIFO empty

Behaviour:
- Reset: every output is 0; accumulators, FIFO pointers and sticky errors are cleared. This applies asynchronously at any time, including mid-beat; a pending return beat is discarded.
- Decode (combinational on rx_st):
  - fmt/type = rx_data[DATA_W-1:DATA_W-8]. Recognised values are 0x0A and 0x0B (no data, 1 header credit, 0 data credits) and 0x4A and 0x4B (with data).
  - With-data case: len = rx_data[DATA_W-23:DATA_W-32] (10 bits). Data credits = 256 when len == 0; otherwise (len+3)>>2, i.e. rounded up.
  - Any other value generates no credits.
- Mode 0: decoded credits are added to the accumulators on the clock edge that samples rx_st.
- Mode 1:
  - Each recognised completion pushes {hcr=1, dcr[8:0]} into the FIFO on the rx_st edge.
  - tlp_done pops the head entry and adds it to the accumulators on the same edge. The accumulators update on the pop edge; data is registered.
  - Push and pop in the same cycle are both honoured, so occupancy is unchanged.
  - Push while full and no pop: the entry is dropped and err_ovf is set.
  - Pop while empty: ignored and err_unf is set.
  - fifo_full is registered and reflects occupancy == DEPTH.
- Return beat:
  - A load occurs when (pend_cplh != 0 or pend_cpld != 0) and (cr_valid == 0 or cr_ready == 1).
  - On load, register cplh_cr = min(pend_cplh, MAX_H_RET) and cpld_cr = min(pend_cpld, MAX_D_RET). Set cr_valid = 1 and subtract the loaded amounts from the accumulators.
  - When cr_ready == 1, cr_valid == 1 and nothing is pending, cr_valid clears next cycle and cplh_cr/cpld_cr return to 0.
  - While cr_valid == 1 and cr_ready == 0, cplh_cr and cpld_cr hold stable.
- Simultaneous add and subtract: next = pend + add - load, computed at full width.
- Saturation: if next exceeds the accumulator maximum, clamp to the maximum and set err_ovf.
- Latency:
  - Mode 0: rx_st at edge N gives pend at N+1 and cr_valid at N+2 (with return idle).
  - Mode 1: tlp_done at edge M gives cr_valid at M+2.
- Throughput: one recognised TLP per cycle and one return beat per cycle. Large data totals are split across consecutive beats.

Test Plan:
- Mode 0, one CplD with rx_data[63:56]=0x4A and len=10, cr_ready=1 -> cr_valid for exactly 1 cycle two cycles after rx_st, with cplh_cr=1 and cpld_cr=3.
- Mode 0, CplD with len=0, then Cpl 0x0A on the next cycle, cr_ready=0 for 5 cycles then 1:
  - First beat: cplh_cr=1, cpld_cr=255, held stable while cr_ready=0.
  - Second beat: cplh_cr=1, cpld_cr=1.
- Mode 0, MemRd header 0x00 and CplD 0x4A without rx_st -> no cr_valid and pend stays 0.
- Mode 1, DEPTH=4, five CplDs with len=4 and no tlp_done:
  - fifo_full=1 after the 4th, and err_ovf=1 after the 5th.
  - Then 4 tlp_done pulses -> total returned cplh=4, cpld=4.
  - A 5th tlp_done -> err_unf=1.
- Mode 1, push and pop in the same cycle while the FIFO holds 2 entries -> occupancy stays 2 and the popped entry's credits appear 2 cycles later.
- rst asserted while cr_valid=1 and pend_cpld=40 -> all outputs 0 immediately; after release there are no beats until new completions arrive.

Source files
------------

// File: rtl/sfif_cpl_credit.sv
// Completion credit return engine: decodes received completion headers into
// header/data credits and returns them to the core over a valid/ready port.
module sfif_cpl_credit #(
    parameter int DATA_W       = 64,
    parameter int RELEASE_MODE = 0,
    parameter int DEPTH        = 16,
    parameter int HCR_W        = 8,
    parameter int DCR_W        = 12,
    parameter int MAX_H_RET    = 8,
    parameter int MAX_D_RET    = 255
) (
    input  logic              clk_125,
    input  logic              rst,
    input  logic              rx_st,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tlp_done,
    input  logic              cr_ready,
    output logic              cr_valid,
    output logic [HCR_W-1:0]  cplh_cr,
    output logic [7:0]        cpld_cr,
    output logic [HCR_W-1:0]  pend_cplh,
    output logic [DCR_W-1:0]  pend_cpld,
    output logic              fifo_full,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int HW = HCR_W + 2;
    localparam int DW = DCR_W + 2;
    localparam logic [HCR_W-1:0] H_MAX = '1;
    localparam logic [DCR_W-1:0] D_MAX = '1;

    function automatic logic [HCR_W-1:0] sat_h(input logic [HW-1:0] v);
        return (v > HW'(H_MAX)) ? H_MAX : v[HCR_W-1:0];
    endfunction

    function automatic logic [DCR_W-1:0] sat_d(input logic [DW-1:0] v);
        return (v > DW'(D_MAX)) ? D_MAX : v[DCR_W-1:0];
    endfunction

    function automatic logic [HCR_W-1:0] min_h(input logic [HCR_W-1:0] v);
        return (v > HCR_W'(MAX_H_RET)) ? HCR_W'(MAX_H_RET) : v;
    endfunction

    function automatic logic [7:0] min_d(input logic [DCR_W-1:0] v);
        return (v > DCR_W'(MAX_D_RET)) ? 8'(MAX_D_RET) : v[7:0];
    endfunction

    logic [7:0] fmt_type;
    logic [9:0] len;
    logic       has_data;
    logic       dec_vld;
    logic [8:0] dec_dcr;
    logic       unused_rx;

    assign unused_rx = ^{rx_data[DATA_W-9 -: 14], rx_data[DATA_W-33:0]};

    always_comb begin
        fmt_type = rx_data[DATA_W-1 -: 8];
        len      = rx_data[DATA_W-23 -: 10];
        has_data = (fmt_type == 8'h4A) || (fmt_type == 8'h4B);
        dec_vld  = rx_st && (has_data || fmt_type == 8'h0A || fmt_type == 8'h0B);
        dec_dcr  = 9'd0;
        if (has_data)
            dec_dcr = (len == 10'd0) ? 9'd256 : 9'((11'(len) + 11'd3) >> 2);
    end

    logic       add_h;
    logic [8:0] add_d;
    logic       fifo_ovf;
    logic       fifo_unf;

    generate
        if (RELEASE_MODE == 0) begin : g_direct
            logic unused_done;
            assign unused_done = tlp_done;
            assign add_h     = dec_vld;
            assign add_d     = dec_vld ? dec_dcr : 9'd0;
            assign fifo_ovf  = 1'b0;
            assign fifo_unf  = 1'b0;
            assign fifo_full = 1'b0;
        end else begin : g_fifo
            localparam int AW = $clog2(DEPTH);
            logic [8:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr, rd_ptr;
            logic [AW:0]   count, count_nxt;
            logic          full_q, do_push, do_pop;

            // Header credit is always 1 per completion, so only data credits are stored.
            always_comb begin
                do_pop    = tlp_done && (count != '0);
                do_push   = dec_vld && ((count != (AW+1)'(DEPTH)) || do_pop);
                count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end

            assign fifo_ovf  = dec_vld && !do_push;
            assign fifo_unf  = tlp_done && (count == '0);
            assign add_h     = do_pop;
            assign add_d     = do_pop ? mem[rd_ptr] : 9'd0;
            assign fifo_full = full_q;

            always_ff @(posedge clk_125 or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    full_q <= 1'b0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + AW'(1);
                    if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                    count  <= count_nxt;
                    full_q <= (count_nxt == (AW+1)'(DEPTH));
                end
            end

            always_ff @(posedge clk_125) begin
                if (do_push) mem[wr_ptr] <= dec_dcr;
            end
        end
    endgenerate

    logic             load;
    logic [HCR_W-1:0] load_h;
    logic [7:0]       load_d;
    logic [HW-1:0]    sum_h;
    logic [DW-1:0]    sum_d;
    logic             ovf_acc;

    // Loaded amounts never exceed pend, so the subtraction cannot wrap.
    always_comb begin
        load    = ((pend_cplh != '0) || (pend_cpld != '0)) && (!cr_valid || cr_ready);
        load_h  = load ? min_h(pend_cplh) : '0;
        load_d  = load ? min_d(pend_cpld) : '0;
        sum_h   = HW'(pend_cplh) + HW'(add_h) - HW'(load_h);
        sum_d   = DW'(pend_cpld) + DW'(add_d) - DW'(load_d);
        ovf_acc = (sum_h > HW'(H_MAX)) || (sum_d > DW'(D_MAX));
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            pend_cplh <= '0;
            pend_cpld <= '0;
            cr_valid  <= 1'b0;
            cplh_cr   <= '0;
            cpld_cr   <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            pend_cplh <= sat_h(sum_h);
            pend_cpld <= sat_d(sum_d);
            if (load) begin
                cr_valid <= 1'b1;
                cplh_cr  <= load_h;
                cpld_cr  <= load_d;
            end else if (!cr_valid || cr_ready) begin
                cr_valid <= 1'b0;
                cplh_cr  <= '0;
                cpld_cr  <= '0;
            end
            err_ovf <= err_ovf | fifo_ovf | ovf_acc;
            err_unf <= err_unf | fifo_unf;
        end
    end

endmodule

// File: tb/tb_sfif_cpl_credit.sv
// Directed bench for sfif_cpl_credit: mode 0 instance (u0) and mode 1 instance with DEPTH=4 (u1).
module tb_sfif_cpl_credit;

    logic clk_125 = 1'b0;
    always #5 clk_125 = ~clk_125;

    logic rst;
    logic rx_st0, tlp_done0, cr_ready0, rx_st1, tlp_done1, cr_ready1;
    logic [63:0] rx_data0, rx_data1;
    logic cr_valid0, fifo_full0, err_ovf0, err_unf0;
    logic cr_valid1, fifo_full1, err_ovf1, err_unf1;
    logic [7:0] cplh_cr0, cpld_cr0, pend_cplh0, cplh_cr1, cpld_cr1, pend_cplh1;
    logic [11:0] pend_cpld0, pend_cpld1;

    int checks = 0;
    int failures = 0;
    int ret_h1 = 0;
    int ret_d1 = 0;

    sfif_cpl_credit #(.DATA_W(64), .RELEASE_MODE(0), .DEPTH(16)) u0 (
        .clk_125(clk_125), .rst(rst), .rx_st(rx_st0), .rx_data(rx_data0), .tlp_done(tlp_done0),
        .cr_ready(cr_ready0), .cr_valid(cr_valid0), .cplh_cr(cplh_cr0), .cpld_cr(cpld_cr0),
        .pend_cplh(pend_cplh0), .pend_cpld(pend_cpld0), .fifo_full(fifo_full0),
        .err_ovf(err_ovf0), .err_unf(err_unf0));

    sfif_cpl_credit #(.DATA_W(64), .RELEASE_MODE(1), .DEPTH(4)) u1 (
        .clk_125(clk_125), .rst(rst), .rx_st(rx_st1), .rx_data(rx_data1), .tlp_done(tlp_done1),
        .cr_ready(cr_ready1), .cr_valid(cr_valid1), .cplh_cr(cplh_cr1), .cpld_cr(cpld_cr1),
        .pend_cplh(pend_cplh1), .pend_cpld(pend_cpld1), .fifo_full(fifo_full1),
        .err_ovf(err_ovf1), .err_unf(err_unf1));

    function automatic logic [63:0] hdr(input logic [7:0] ft, input logic [9:0] len);
        return {ft, 14'd0, len, 32'd0};
    endfunction

    task automatic step();
        @(posedge clk_125);
        #1;
        if (cr_valid1 && cr_ready1) begin
            ret_h1 += int'(cplh_cr1);
            ret_d1 += int'(cpld_cr1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_st0 = 1'b0; rx_data0 = '0; tlp_done0 = 1'b0; cr_ready0 = 1'b0;
        rx_st1 = 1'b0; rx_data1 = '0; tlp_done1 = 1'b0; cr_ready1 = 1'b0;
        @(posedge clk_125);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_st0 = 1'b0; rx_data0 = '0; tlp_done0 = 1'b0; cr_ready0 = 1'b0;
        rx_st1 = 1'b0; rx_data1 = '0; tlp_done1 = 1'b0; cr_ready1 = 1'b0;
        repeat (2) @(posedge clk_125);
        #1;
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0, pend_cplh0, pend_cpld0, fifo_full0, err_ovf0, err_unf0} !== 40'd0) begin failures++; $display("FAIL reset_u0 got=%h exp=0", {cr_valid0, cplh_cr0, cpld_cr0, pend_cplh0, pend_cpld0, fifo_full0, err_ovf0, err_unf0}); end
        checks++; if ({cr_valid1, cplh_cr1, cpld_cr1, pend_cplh1, pend_cpld1, fifo_full1, err_ovf1, err_unf1} !== 40'd0) begin failures++; $display("FAIL reset_u1 got=%h exp=0", {cr_valid1, cplh_cr1, cpld_cr1, pend_cplh1, pend_cpld1, fifo_full1, err_ovf1, err_unf1}); end
        rst = 1'b0;
        step();
        checks++; if ({cr_valid0, cr_valid1} !== 2'b00) begin failures++; $display("FAIL reset_release_valid got=%b exp=00", {cr_valid0, cr_valid1}); end
    endtask

    task automatic test_single_cpld();
        cr_ready0 = 1'b1;
        rx_st0 = 1'b1; rx_data0 = hdr(8'h4A, 10'd10);
        step();
        rx_st0 = 1'b0; rx_data0 = '0;
        checks++; if (cr_valid0 !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0d exp=0", cr_valid0); end
        checks++; if ({pend_cplh0, pend_cpld0} !== {8'd1, 12'd3}) begin failures++; $display("FAIL single_pend got=%0d/%0d exp=1/3", pend_cplh0, pend_cpld0); end
        step();
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0} !== {1'b1, 8'd1, 8'd3}) begin failures++; $display("FAIL single_beat got=%0d/%0d/%0d exp=1/1/3", cr_valid0, cplh_cr0, cpld_cr0); end
        checks++; if ({pend_cplh0, pend_cpld0} !== 20'd0) begin failures++; $display("FAIL single_pend_drain got=%0d/%0d exp=0/0", pend_cplh0, pend_cpld0); end
        step();
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0} !== 17'd0) begin failures++; $display("FAIL single_clear got=%0d/%0d/%0d exp=0/0/0", cr_valid0, cplh_cr0, cpld_cr0); end
    endtask

    task automatic test_backpressure();
        cr_ready0 = 1'b0;
        rx_st0 = 1'b1; rx_data0 = hdr(8'h4A, 10'd0);
        step();
        rx_data0 = hdr(8'h0A, 10'd0);
        step();
        rx_st0 = 1'b0; rx_data0 = '0;
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0} !== {1'b1, 8'd1, 8'd255}) begin failures++; $display("FAIL bp_first_beat got=%0d/%0d/%0d exp=1/1/255", cr_valid0, cplh_cr0, cpld_cr0); end
        checks++; if ({pend_cplh0, pend_cpld0} !== {8'd1, 12'd1}) begin failures++; $display("FAIL bp_pend got=%0d/%0d exp=1/1", pend_cplh0, pend_cpld0); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({cr_valid0, cplh_cr0, cpld_cr0} !== {1'b1, 8'd1, 8'd255}) begin failures++; $display("FAIL bp_hold%0d got=%0d/%0d/%0d exp=1/1/255", i, cr_valid0, cplh_cr0, cpld_cr0); end
        end
        cr_ready0 = 1'b1;
        step();
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0} !== {1'b1, 8'd1, 8'd1}) begin failures++; $display("FAIL bp_second_beat got=%0d/%0d/%0d exp=1/1/1", cr_valid0, cplh_cr0, cpld_cr0); end
        step();
        checks++; if ({cr_valid0, pend_cplh0, pend_cpld0} !== 21'd0) begin failures++; $display("FAIL bp_idle got=%0d/%0d/%0d exp=0/0/0", cr_valid0, pend_cplh0, pend_cpld0); end
    endtask

    task automatic test_ignore();
        cr_ready0 = 1'b1;
        rx_st0 = 1'b1; rx_data0 = hdr(8'h00, 10'd5);
        step();
        rx_st0 = 1'b0; rx_data0 = hdr(8'h4A, 10'd10);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({cr_valid0, pend_cplh0, pend_cpld0} !== 21'd0) begin failures++; $display("FAIL ignore%0d got=%0d/%0d/%0d exp=0/0/0", i, cr_valid0, pend_cplh0, pend_cpld0); end
            step();
        end
        rx_data0 = '0;
    endtask

    task automatic test_mode1_overflow();
        do_reset();
        cr_ready1 = 1'b1;
        rx_st1 = 1'b1; rx_data1 = hdr(8'h4A, 10'd4);
        repeat (3) step();
        checks++; if (fifo_full1 !== 1'b0) begin failures++; $display("FAIL m1_full_after3 got=%0d exp=0", fifo_full1); end
        step();
        checks++; if ({fifo_full1, err_ovf1} !== 2'b10) begin failures++; $display("FAIL m1_full_after4 got=%b exp=10", {fifo_full1, err_ovf1}); end
        step();
        rx_st1 = 1'b0; rx_data1 = '0;
        checks++; if ({fifo_full1, err_ovf1} !== 2'b11) begin failures++; $display("FAIL m1_ovf_after5 got=%b exp=11", {fifo_full1, err_ovf1}); end
        checks++; if ({cr_valid1, pend_cplh1, pend_cpld1} !== 21'd0) begin failures++; $display("FAIL m1_no_release got=%0d/%0d/%0d exp=0/0/0", cr_valid1, pend_cplh1, pend_cpld1); end
        ret_h1 = 0; ret_d1 = 0;
        tlp_done1 = 1'b1;
        repeat (4) step();
        tlp_done1 = 1'b0;
        checks++; if (fifo_full1 !== 1'b0) begin failures++; $display("FAIL m1_full_after_pops got=%0d exp=0", fifo_full1); end
        repeat (4) step();
        checks++; if (ret_h1 != 4 || ret_d1 != 4) begin failures++; $display("FAIL m1_returned got=%0d/%0d exp=4/4", ret_h1, ret_d1); end
        checks++; if (err_unf1 !== 1'b0) begin failures++; $display("FAIL m1_unf_early got=%0d exp=0", err_unf1); end
        tlp_done1 = 1'b1;
        step();
        tlp_done1 = 1'b0;
        checks++; if (err_unf1 !== 1'b1) begin failures++; $display("FAIL m1_unf got=%0d exp=1", err_unf1); end
        step();
        checks++; if (cr_valid1 !== 1'b0) begin failures++; $display("FAIL m1_unf_no_beat got=%0d exp=0", cr_valid1); end
    endtask

    task automatic test_push_pop();
        do_reset();
        cr_ready1 = 1'b1;
        rx_st1 = 1'b1; rx_data1 = hdr(8'h4A, 10'd8);
        step();
        rx_data1 = hdr(8'h4A, 10'd12);
        step();
        rx_data1 = hdr(8'h4A, 10'd20);
        tlp_done1 = 1'b1;
        step();
        tlp_done1 = 1'b0;
        rx_data1 = hdr(8'h4A, 10'd4);
        checks++; if ({pend_cplh1, pend_cpld1, cr_valid1, fifo_full1} !== {8'd1, 12'd2, 2'b00}) begin failures++; $display("FAIL pp_pend got=%0d/%0d/%0d/%0d exp=1/2/0/0", pend_cplh1, pend_cpld1, cr_valid1, fifo_full1); end
        step();
        checks++; if ({cr_valid1, cplh_cr1, cpld_cr1, fifo_full1} !== {1'b1, 8'd1, 8'd2, 1'b0}) begin failures++; $display("FAIL pp_beat got=%0d/%0d/%0d/%0d exp=1/1/2/0", cr_valid1, cplh_cr1, cpld_cr1, fifo_full1); end
        step();
        rx_st1 = 1'b0; rx_data1 = '0;
        checks++; if (fifo_full1 !== 1'b1) begin failures++; $display("FAIL pp_occupancy got=%0d exp=1", fifo_full1); end
        tlp_done1 = 1'b1;
        step();
        tlp_done1 = 1'b0;
        checks++; if (pend_cpld1 !== 12'd3) begin failures++; $display("FAIL pp_next_head got=%0d exp=3", pend_cpld1); end
        step();
        checks++; if ({cr_valid1, cpld_cr1} !== {1'b1, 8'd3}) begin failures++; $display("FAIL pp_next_beat got=%0d/%0d exp=1/3", cr_valid1, cpld_cr1); end
    endtask

    task automatic test_reset_midbeat();
        do_reset();
        cr_ready0 = 1'b0;
        rx_st0 = 1'b1; rx_data0 = hdr(8'h4A, 10'd0);
        step();
        rx_data0 = hdr(8'h4A, 10'd156);
        step();
        rx_st0 = 1'b0; rx_data0 = '0;
        checks++; if ({cr_valid0, cpld_cr0, pend_cpld0} !== {1'b1, 8'd255, 12'd40}) begin failures++; $display("FAIL mid_setup got=%0d/%0d/%0d exp=1/255/40", cr_valid0, cpld_cr0, pend_cpld0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({cr_valid0, cplh_cr0, cpld_cr0, pend_cplh0, pend_cpld0, fifo_full0, err_ovf0, err_unf0} !== 40'd0) begin failures++; $display("FAIL mid_async_reset got=%h exp=0", {cr_valid0, cplh_cr0, cpld_cr0, pend_cplh0, pend_cpld0, fifo_full0, err_ovf0, err_unf0}); end
        @(posedge clk_125);
        #1;
        rst = 1'b0;
        cr_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({cr_valid0, pend_cplh0, pend_cpld0} !== 21'd0) begin failures++; $display("FAIL mid_after%0d got=%0d/%0d/%0d exp=0/0/0", i, cr_valid0, pend_cplh0, pend_cpld0); end
        end
    endtask

    initial begin
        test_reset();
        test_single_cpld();
        test_backpressure();
        test_ignore();
        test_mode1_overflow();
        test_push_pop();
        test_reset_midbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
